sync_fifo: RTL and testbench

Single-clock, parametrised FIFO: the same-domain successor to the dual-clock FIFO, used where producer and consumer share one clock. It adds registered occupancy count, programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain, for example between the register-file/ALU path and a UART TX serializer.

---
 rtl/sync_fifo.sv | 125 ++++++++++++
 tb/tb_sync_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy, almost-full/empty thresholds,
// selectable registered or first-word-fall-through read data, and sticky error flags.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR       = 3,
    parameter int AF_LEVEL   = (1 << ADDR) - 2,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rinc,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR;
    localparam logic [ADDR:0] DEPTH_CNT = (ADDR + 1)'(DEPTH);
    localparam logic [ADDR:0] AF_CNT    = (ADDR + 1)'(AF_LEVEL);
    localparam logic [ADDR:0] AE_CNT    = (ADDR + 1)'(AE_LEVEL);
    localparam logic [ADDR:0] PTR_ONE   = (ADDR + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR:0]         wptr_r;
    logic [ADDR:0]         rptr_r;
    logic [ADDR:0]         count_r;
    logic                  overflow_r;
    logic                  underflow_r;
    logic                  wr_acc_s;
    logic                  rd_acc_s;

    // Acceptance depends only on registered state, so there is no pass-through when full/empty.
    always_comb begin
        wr_acc_s = winc & ~wfull;
        rd_acc_s = rinc & ~rempty;
    end

    // Status flags decoded from the registered count only.
    always_comb begin
        wfull        = (count_r == DEPTH_CNT);
        rempty       = (count_r == {(ADDR + 1){1'b0}});
        almost_full  = (count_r >= AF_CNT);
        almost_empty = (count_r <= AE_CNT);
    end

    assign count     = count_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

    // Storage array; intentionally not reset.
    always_ff @(posedge CLK) begin
        if (wr_acc_s) begin
            mem_r[wptr_r[ADDR-1:0]] <= wdata;
        end
    end

    // Pointers and occupancy; reset discards all contents.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr_r  <= {(ADDR + 1){1'b0}};
            rptr_r  <= {(ADDR + 1){1'b0}};
            count_r <= {(ADDR + 1){1'b0}};
        end else begin
            if (wr_acc_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + PTR_ONE;
                2'b01:   count_r <= count_r - PTR_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags: a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge CLK) begin
        if (RST) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (winc && wfull) begin
                overflow_r <= 1'b1;
            end else if (clr_err) begin
                overflow_r <= 1'b0;
            end
            if (rinc && rempty) begin
                underflow_r <= 1'b1;
            end else if (clr_err) begin
                underflow_r <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = mem_r[rptr_r[ADDR-1:0]];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_r;

            // Registered read port: loads the head word on an accepted read, holds otherwise.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    rdata_r <= {DATA_WIDTH{1'b0}};
                end else if (rd_acc_s) begin
                    rdata_r <= mem_r[rptr_r[ADDR-1:0]];
                end
            end

            assign rdata = rdata_r;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: four sync_fifo variants share one stimulus stream and
// are compared every cycle against a queue-based reference model.
module tb_sync_fifo;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       winc = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rinc = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] d0_rdata, a0_rdata, a2_rdata, fw_rdata;
    logic       d0_wfull, a0_wfull, a2_wfull, fw_wfull;
    logic       d0_rempty, a0_rempty, a2_rempty, fw_rempty;
    logic       d0_af, a0_af, a2_af, fw_af;
    logic       d0_ae, a0_ae, a2_ae, fw_ae;
    logic [3:0] d0_count, a0_count, a2_count, fw_count;
    logic       d0_ovf, a0_ovf, a2_ovf, fw_ovf;
    logic       d0_unf, a0_unf, a2_unf, fw_unf;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_rdata = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    sync_fifo dut0 (
        .CLK(CLK), .RST(RST), .winc(winc), .wdata(wdata), .rinc(rinc), .clr_err(clr_err),
        .rdata(d0_rdata), .wfull(d0_wfull), .rempty(d0_rempty), .almost_full(d0_af),
        .almost_empty(d0_ae), .count(d0_count), .overflow(d0_ovf), .underflow(d0_unf));

    sync_fifo #(.AE_LEVEL(0)) dut_ae0 (
        .CLK(CLK), .RST(RST), .winc(winc), .wdata(wdata), .rinc(rinc), .clr_err(clr_err),
        .rdata(a0_rdata), .wfull(a0_wfull), .rempty(a0_rempty), .almost_full(a0_af),
        .almost_empty(a0_ae), .count(a0_count), .overflow(a0_ovf), .underflow(a0_unf));

    sync_fifo #(.AE_LEVEL(2)) dut_ae2 (
        .CLK(CLK), .RST(RST), .winc(winc), .wdata(wdata), .rinc(rinc), .clr_err(clr_err),
        .rdata(a2_rdata), .wfull(a2_wfull), .rempty(a2_rempty), .almost_full(a2_af),
        .almost_empty(a2_ae), .count(a2_count), .overflow(a2_ovf), .underflow(a2_unf));

    sync_fifo #(.FWFT(1)) dut_fw (
        .CLK(CLK), .RST(RST), .winc(winc), .wdata(wdata), .rinc(rinc), .clr_err(clr_err),
        .rdata(fw_rdata), .wfull(fw_wfull), .rempty(fw_rempty), .almost_full(fw_af),
        .almost_empty(fw_ae), .count(fw_count), .overflow(fw_ovf), .underflow(fw_unf));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int         n;
        logic [3:0] diff;
        n = q.size();
        chk("count", 32'(d0_count), 32'(n));
        chk("wfull", 32'(d0_wfull), 32'(n == 8));
        chk("rempty", 32'(d0_rempty), 32'(n == 0));
        chk("almost_full", 32'(d0_af), 32'(n >= 6));
        chk("almost_empty_ae1", 32'(d0_ae), 32'(n <= 1));
        chk("almost_empty_ae0", 32'(a0_ae), 32'(n <= 0));
        chk("almost_empty_ae2", 32'(a2_ae), 32'(n <= 2));
        chk("overflow", 32'(d0_ovf), 32'(m_ovf));
        chk("underflow", 32'(d0_unf), 32'(m_unf));
        chk("rdata_reg", 32'(d0_rdata), 32'(m_rdata));
        chk("fw_count", 32'(fw_count), 32'(n));
        chk("fw_rempty", 32'(fw_rempty), 32'(n == 0));
        if (n != 0) begin
            chk("fw_rdata", 32'(fw_rdata), 32'(q[0]));
        end
        diff = dut0.wptr_r - dut0.rptr_r;
        chk("ptr_invariant", 32'(diff), 32'(n));
        diff = dut_fw.wptr_r - dut_fw.rptr_r;
        chk("fw_ptr_invariant", 32'(diff), 32'(n));
    endtask

    // One clock cycle: apply inputs, advance the model with the same rules, then compare.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic c, input logic rs);
        logic full, empty;
        winc = w; wdata = d; rinc = r; clr_err = c; RST = rs;
        @(posedge CLK);
        if (rs) begin
            q.delete();
            m_rdata = 8'h00;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            full  = (q.size() == 8);
            empty = (q.size() == 0);
            if (r && !empty) m_rdata = q.pop_front();
            if (w && !full) q.push_back(d);
            if (w && full) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
            if (r && empty) m_unf = 1'b1;
            else if (c) m_unf = 1'b0;
        end
        #1;
        check_all();
        winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; RST = 1'b0;
    endtask

    initial begin
        int wn;
        int cyc;

        // Reset state
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_count", 32'(d0_count), 32'd0);
        chk("rst_rempty", 32'(d0_rempty), 32'd1);
        chk("rst_rdata", 32'(d0_rdata), 32'd0);

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            if (i == 6) chk("af_rise_at_6", 32'(d0_af), 32'd1);
        end
        chk("full_at_8", 32'(d0_wfull), 32'd1);

        // 9th write rejected, sets overflow
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        chk("ovf_count_stays", 32'(d0_count), 32'd8);
        chk("ovf_set", 32'(d0_ovf), 32'd1);

        // Drain 8 words in order
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk("drain_order", 32'(d0_rdata), 32'(i));
        end

        // Underflow, then clr_err together with a new underflow: set wins
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("unf_set_wins", 32'(d0_unf), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("clr_ovf", 32'(d0_ovf), 32'd0);
        chk("clr_unf", 32'(d0_unf), 32'd0);

        // Simultaneous at count 0
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        chk("rw_at_0_count", 32'(d0_count), 32'd1);
        chk("rw_at_0_unf", 32'(d0_unf), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Simultaneous at count 8
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        chk("rw_at_8_count", 32'(d0_count), 32'd7);
        chk("rw_at_8_ovf", 32'(d0_ovf), 32'd1);

        // Simultaneous at count 4
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
            chk("rw_at_4_count", 32'(d0_count), 32'd4);
        end

        // FWFT: single word into empty FIFO
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("fwft_word", 32'(fw_rdata), 32'hA5);
        chk("fwft_not_empty", 32'(fw_rempty), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("fwft_empty_after", 32'(fw_rempty), 32'd1);

        // Reset mid-operation at count 5 with winc/rinc
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        chk("midrst_count", 32'(d0_count), 32'd0);
        chk("midrst_rdata", 32'(d0_rdata), 32'd0);
        chk("midrst_af", 32'(d0_af), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("midrst_no_data", 32'(d0_rdata), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Random stream of 40 accepted writes through the wrap
        wn = 0;
        cyc = 0;
        while (wn < 40 && cyc < 3000) begin
            logic w, r;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (w && q.size() < 8) wn++;
            step(w, 8'($urandom), r, 1'b0, 1'b0);
            cyc++;
        end
        chk("stream_bound", 32'(wn), 32'd40);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("stream_drained", 32'(d0_rempty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
